controle_es: RTL and testbench

- I/O sequencer between the DE2 board and the single-cycle processor core.
- Consumes the core's OpIn/OpOut/OpHalt strobes and its 28-bit output data bus.
- Produces the core's clock-enable, which stalls the core on an input instruction until the user presses a debounced confirm key.
- Latches output values and converts them with a sequential double-dabble into the 7-segment display pattern, with leading zeros blanked.

---
 rtl/controle_es.sv | 178 +++++++++++++++++
 tb/tb_controle_es.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_es.sv
// I/O sequencer: stalls the core on input until a debounced key press, renders output values on 7-seg.
// Latency: cpu_en is combinational from state/strobes; display updates 28 cycles after the output capture.
// Backpressure: a new output capture aborts a running conversion (latest value wins); a held key never re-releases.
module controle_es #(
    parameter int DIGITS          = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  botao_n,
    input  logic                  OpIn,
    input  logic                  OpOut,
    input  logic                  OpHalt,
    input  logic [27:0]           dado_saida,
    output logic                  cpu_en,
    output logic                  aguardando,
    output logic                  parado,
    output logic                  ocupado,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int NB    = (DIGITS > 9) ? DIGITS : 9;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] EXEC    = 2'd0;
    localparam logic [1:0] WAIT_IN = 2'd1;
    localparam logic [1:0] IN_DONE = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [7*DIGITS-1:0] HEX_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Key path: synchroniser idles at the released (high) level.
    logic             sync_q1;
    logic             sync_q2;
    logic             key_level;
    logic             press;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            key_level <= 1'b1;
            db_cnt    <= '0;
            press     <= 1'b0;
        end else begin
            sync_q1 <= botao_n;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == key_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                key_level <= sync_q2;
                db_cnt    <= '0;
                press     <= !sync_q2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    logic [1:0] state;
    logic [1:0] state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            EXEC: begin
                if (OpHalt)    state_nxt = HALT;
                else if (OpIn) state_nxt = WAIT_IN;
            end
            WAIT_IN: if (press) state_nxt = IN_DONE;
            IN_DONE: state_nxt = EXEC;
            HALT:    state_nxt = HALT;
            default: state_nxt = EXEC;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EXEC;
        else          state <= state_nxt;
    end

    assign cpu_en     = ((state == EXEC) && !OpIn && !OpHalt) || (state == IN_DONE);
    assign aguardando = (state == WAIT_IN);
    assign parado     = (state == HALT);

    logic                capture;
    logic [27:0]         bin_q;
    logic [4*NB-1:0]     bcd_q;
    logic [4*NB-1:0]     bcd_adj;
    logic [4*NB-1:0]     bcd_shift;
    logic [4:0]          step_q;
    logic                ovf_q;
    logic [7*DIGITS-1:0] hex_nxt;
    logic                seen;
    logic [3:0]          digit;

    assign capture = (state == EXEC) && cpu_en && OpOut;

    // One double-dabble step: add-3 correction, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[4*NB-2:0], bin_q[27]};
    end

    // Digits above the value's top digit are zero when no overflow, so scanning DIGITS is enough.
    always_comb begin
        hex_nxt = '1;
        seen    = 1'b0;
        digit   = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = bcd_shift[4*i +: 4];
            if (digit != 4'd0) seen = 1'b1;
            if (ovf_q)                hex_nxt[7*i +: 7] = SEG_DASH;
            else if (seen || i == 0)  hex_nxt[7*i +: 7] = seg7(digit);
            else                      hex_nxt[7*i +: 7] = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            ovf_q   <= 1'b0;
            ocupado <= 1'b0;
            hex     <= HEX_RESET;
        end else if (capture) begin
            bin_q   <= dado_saida;
            bcd_q   <= '0;
            step_q  <= '0;
            ovf_q   <= ({36'd0, dado_saida} >= LIMIT);
            ocupado <= 1'b1;
        end else if (ocupado) begin
            bin_q  <= bin_q << 1;
            bcd_q  <= bcd_shift;
            step_q <= step_q + 5'd1;
            if (step_q == 5'd27) begin
                ocupado <= 1'b0;
                hex     <= hex_nxt;
            end
        end
    end

endmodule

// File: tb/tb_controle_es.sv
// Directed bench for controle_es: key stall/release, halt, and 7-segment conversion.
module tb_controle_es;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, BL = 7'b1111111, DS = 7'b0111111;
    localparam logic [55:0] HEX_RESET = {BL, BL, BL, BL, BL, BL, BL, S0};

    logic        clock = 1'b0;
    logic        reset_n;
    logic        botao_n;
    logic        OpIn;
    logic        OpOut;
    logic        OpHalt;
    logic [27:0] dado_saida;
    logic        cpu_en;
    logic        aguardando;
    logic        parado;
    logic        ocupado;
    logic [55:0] hex;

    logic [55:0] shown;
    int          n_tests = 0;
    int          n_fail  = 0;

    controle_es #(.DIGITS(8), .DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .botao_n    (botao_n),
        .OpIn       (OpIn),
        .OpOut      (OpOut),
        .OpHalt     (OpHalt),
        .dado_saida (dado_saida),
        .cpu_en     (cpu_en),
        .aguardando (aguardando),
        .parado     (parado),
        .ocupado    (ocupado),
        .hex        (hex)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; botao_n = 1'b1; OpIn = 1'b0; OpOut = 1'b0; OpHalt = 1'b0; dado_saida = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        n_tests++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_en: got %b expected 1", cpu_en); end
        n_tests++; if (hex !== HEX_RESET) begin n_fail++; $display("FAIL rst_hex: got %h expected %h", hex, HEX_RESET); end
        n_tests++; if ({aguardando, parado, ocupado} !== 3'b000) begin
            n_fail++; $display("FAIL rst_leds: got %b expected 000", {aguardando, parado, ocupado});
        end
        shown = HEX_RESET;
    endtask

    task automatic test_input();
        int highs;
        bit seen;
        OpIn = 1'b1;
        #1;
        n_tests++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL in_stall: got %b expected 0", cpu_en); end
        step();
        n_tests++; if (aguardando !== 1'b1) begin n_fail++; $display("FAIL in_wait_led: got %b expected 1", aguardando); end
        highs = 0;
        for (int g = 0; g < 3; g++) begin
            botao_n = 1'b0;
            repeat (3) begin step(); if (cpu_en) highs++; end
            botao_n = 1'b1;
            repeat (3) begin step(); if (cpu_en) highs++; end
        end
        n_tests++; if (highs !== 0) begin n_fail++; $display("FAIL in_glitch: got %0d release cycles expected 0", highs); end
        // Stable press: exactly one enable cycle, then stalled again while OpIn stays high.
        botao_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin step(); if (cpu_en) seen = 1'b1; end
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL in_release: got no cpu_en pulse expected one"); end
        step();
        n_tests++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL in_one_cycle: got %b expected 0", cpu_en); end
        OpIn = 1'b0;
        #1;
        n_tests++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL in_resume: got %b expected 1", cpu_en); end
        step();
        OpIn = 1'b1;
        highs = 0;
        repeat (10) begin step(); if (cpu_en) highs++; end
        n_tests++; if (highs !== 0) begin n_fail++; $display("FAIL in_hold_once: got %0d release cycles expected 0", highs); end
        botao_n = 1'b1;
        repeat (8) step();
        botao_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin step(); if (cpu_en) seen = 1'b1; end
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL in_second_press: got no cpu_en pulse expected one"); end
        step();
        OpIn = 1'b0;
        botao_n = 1'b1;
        repeat (8) step();
        n_tests++; if ({cpu_en, aguardando} !== 2'b10) begin
            n_fail++; $display("FAIL in_idle: got cpu_en,aguardando=%b expected 10", {cpu_en, aguardando});
        end
    endtask

    task automatic test_conv(input logic [27:0] value, input logic [55:0] expected, input string name);
        int bad;
        dado_saida = value;
        OpOut = 1'b1;
        step();
        OpOut = 1'b0;
        bad = 0;
        if (ocupado !== 1'b1 || hex !== shown) bad++;
        repeat (27) begin step(); if (ocupado !== 1'b1 || hex !== shown) bad++; end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL %s_busy: got %0d bad cycles expected 0", name, bad); end
        step();
        n_tests++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL %s_done: got ocupado=%b expected 0", name, ocupado); end
        n_tests++; if (hex !== expected) begin n_fail++; $display("FAIL %s_hex: got %h expected %h", name, hex, expected); end
        shown = expected;
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [55:0] exp42;
        exp42 = {BL, BL, BL, BL, BL, BL, S4, S2};
        dado_saida = 28'd5678;
        OpOut = 1'b1;
        step();
        OpOut = 1'b0;
        bad = 0;
        repeat (9) begin step(); if (ocupado !== 1'b1 || hex !== shown) bad++; end
        dado_saida = 28'd42;
        OpOut = 1'b1;
        step();
        OpOut = 1'b0;
        repeat (27) begin step(); if (ocupado !== 1'b1 || hex !== shown) bad++; end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_hold: got %0d bad cycles expected 0", bad); end
        step();
        n_tests++; if (hex !== exp42 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL b2b_hex: got %h ocupado=%b expected %h ocupado=0", hex, ocupado, exp42);
        end
        shown = exp42;
    endtask

    task automatic test_halt();
        int highs;
        OpHalt = 1'b1;
        OpIn = 1'b1;
        #1;
        n_tests++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_comb: got %b expected 0", cpu_en); end
        step();
        n_tests++; if ({parado, aguardando} !== 2'b10) begin
            n_fail++; $display("FAIL halt_leds: got parado,aguardando=%b expected 10", {parado, aguardando});
        end
        highs = 0;
        botao_n = 1'b0;
        repeat (10) begin step(); if (cpu_en) highs++; end
        botao_n = 1'b1;
        repeat (8) begin step(); if (cpu_en) highs++; end
        OpHalt = 1'b0;
        OpIn = 1'b0;
        dado_saida = 28'd7;
        OpOut = 1'b1;
        repeat (3) begin step(); if (cpu_en) highs++; end
        OpOut = 1'b0;
        n_tests++; if (highs !== 0) begin n_fail++; $display("FAIL halt_stuck: got %0d enable cycles expected 0", highs); end
        n_tests++; if ({parado, ocupado} !== 2'b10) begin
            n_fail++; $display("FAIL halt_no_capture: got parado,ocupado=%b expected 10", {parado, ocupado});
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        n_tests++; if ({cpu_en, parado} !== 2'b10) begin
            n_fail++; $display("FAIL rmid_exit_halt: got cpu_en,parado=%b expected 10", {cpu_en, parado});
        end
        shown = HEX_RESET;
        test_conv(28'd7, {BL, BL, BL, BL, BL, BL, BL, S7}, "conv_7");
        dado_saida = 28'd1234;
        OpOut = 1'b1;
        step();
        OpOut = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        n_tests++; if (hex !== HEX_RESET || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got %h ocupado=%b expected %h ocupado=0", hex, ocupado, HEX_RESET);
        end
        step();
        reset_n = 1'b1;
        step();
        n_tests++; if ({cpu_en, aguardando, parado} !== 3'b100) begin
            n_fail++; $display("FAIL rmid_exec: got %b expected 100", {cpu_en, aguardando, parado});
        end
        bad = 0;
        repeat (30) begin step(); if (hex !== HEX_RESET || ocupado !== 1'b0) bad++; end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_discard: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_input();
        test_conv(28'd1234, {BL, BL, BL, BL, S1, S2, S3, S4}, "conv_1234");
        test_conv(28'd0, {BL, BL, BL, BL, BL, BL, BL, S0}, "conv_0");
        test_conv(28'd99999999, {8{S9}}, "conv_max");
        test_conv(28'd100000000, {8{DS}}, "conv_ovf");
        test_conv(28'd10203, {BL, BL, BL, S1, S0, S2, S0, S3}, "conv_10203");
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
